// File: rtl/toggle_activity_monitor.sv
// Counts per-bit 0<->1 transitions of probe over a window_len-cycle window; result after N+1 edges from start.
// Result held in DONE until res_valid && res_ready; abort in ARM/COUNT discards the measurement.
module toggle_activity_monitor #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int TOT_W = 12,
    parameter int WIN_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [WIN_W-1:0]         window_len,
    input  logic [WIDTH-1:0]         probe,
    output logic                     busy,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH*CNT_W-1:0]   toggle_cnt,
    output logic [TOT_W-1:0]         total_cnt
);

    localparam int POP_W = $clog2(WIDTH + 1);
    localparam int SUM_W = TOT_W + POP_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TOT_W-1:0] TOT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;

    state_t              state;
    logic [WIDTH-1:0]    prev;
    logic [WIN_W-1:0]    cyc_left;
    logic [WIDTH-1:0]    diff;
    logic [POP_W-1:0]    pop;
    logic [SUM_W-1:0]    sum;
    logic [TOT_W-1:0]    total_next;
    logic [WIDTH*CNT_W-1:0] toggle_next;

    assign diff = probe ^ prev;

    always_comb begin
        pop = '0;
        for (int k = 0; k < WIDTH; k++) begin
            pop = pop + POP_W'(diff[k]);
        end
        // Saturate on the widened sum so a large popcount can never wrap past the max.
        sum        = SUM_W'(total_cnt) + SUM_W'(pop);
        total_next = (sum > SUM_W'(TOT_MAX)) ? TOT_MAX : sum[TOT_W-1:0];
        toggle_next = toggle_cnt;
        for (int k = 0; k < WIDTH; k++) begin
            if (diff[k] && (toggle_cnt[k*CNT_W +: CNT_W] != CNT_MAX)) begin
                toggle_next[k*CNT_W +: CNT_W] = toggle_cnt[k*CNT_W +: CNT_W] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prev       <= '0;
            cyc_left   <= '0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
            toggle_cnt <= '0;
            total_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cyc_left   <= window_len;
                        toggle_cnt <= '0;
                        total_cnt  <= '0;
                        state      <= ARM;
                        busy       <= (window_len != '0);
                    end
                end
                ARM: begin
                    if (abort) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        toggle_cnt <= '0;
                        total_cnt  <= '0;
                    end else if (cyc_left == '0) begin
                        // Zero-length window: pass through with busy low and report empty counts.
                        state     <= DONE;
                        res_valid <= 1'b1;
                    end else begin
                        prev  <= probe;
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (abort) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        toggle_cnt <= '0;
                        total_cnt  <= '0;
                    end else begin
                        prev       <= probe;
                        toggle_cnt <= toggle_next;
                        total_cnt  <= total_next;
                        cyc_left   <= cyc_left - WIN_W'(1);
                        if (cyc_left == WIN_W'(1)) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            res_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Randomized bench for toggle_activity_monitor; two instances (8/12-bit and 4/5-bit counters) share stimulus.
module tb_toggle_activity_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        res_ready;
    logic [7:0]  window_len;
    logic [3:0]  probe;
    logic        busy_a, valid_a, busy_b, valid_b;
    logic [31:0] tog_a;
    logic [11:0] tot_a;
    logic [15:0] tog_b;
    logic [4:0]  tot_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] s[$];
    int exp_a[4];
    int exp_b[4];
    int etot_a, etot_b;

    always #5 clk = ~clk;

    toggle_activity_monitor dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .window_len(window_len), .probe(probe), .busy(busy_a),
        .res_valid(valid_a), .res_ready(res_ready),
        .toggle_cnt(tog_a), .total_cnt(tot_a)
    );

    toggle_activity_monitor #(.WIDTH(4), .CNT_W(4), .TOT_W(5), .WIN_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .window_len(window_len), .probe(probe), .busy(busy_b),
        .res_valid(valid_b), .res_ready(res_ready),
        .toggle_cnt(tog_b), .total_cnt(tot_b)
    );

    function automatic logic [3:0] gen(input int kind, input int idx);
        case (kind)
            0:       return 4'(idx);
            1:       return 4'hA;
            2:       return (idx % 2 == 1) ? 4'hF : 4'h0;
            default: return 4'($urandom);
        endcase
    endfunction

    // Reference: count bit differences between consecutive sampled probe values, then clamp.
    task automatic compute_model();
        int raw[4];
        int rawtot;
        logic [3:0] d;
        rawtot = 0;
        for (int k = 0; k < 4; k++) raw[k] = 0;
        for (int i = 1; i < s.size(); i++) begin
            d = s[i] ^ s[i-1];
            for (int k = 0; k < 4; k++) begin
                raw[k] += int'(d[k]);
                rawtot += int'(d[k]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            exp_a[k] = (raw[k] > 255) ? 255 : raw[k];
            exp_b[k] = (raw[k] > 15) ? 15 : raw[k];
        end
        etot_a = (rawtot > 4095) ? 4095 : rawtot;
        etot_b = (rawtot > 31) ? 31 : rawtot;
    endtask

    // Drives one measurement; lat = edges after the start edge until res_valid is seen.
    task automatic run_window(input int n, input int kind, output int lat, output bit busy_ok);
        int c;
        s.delete();
        window_len = 8'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        busy_ok = 1'b1;
        while (valid_a !== 1'b1 && c < n + 8) begin
            if (busy_a !== (n != 0)) busy_ok = 1'b0;
            probe = gen(kind, s.size());
            s.push_back(probe);
            @(posedge clk); #1;
            c++;
        end
        lat = c;
        compute_model();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
        window_len = '0; probe = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy_a, valid_a, tog_a, tot_a, busy_b, valid_b, tog_b, tot_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b valid=%b tog=%h tot=%0d required all zero",
                     busy_a, valid_a, tog_a, tot_a);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_counter();
        int lat; bit bok;
        run_window(16, 0, lat, bok);
        n_checks++;
        if (lat !== 17) begin n_fail++; $display("FAIL counter_latency: got %0d required 17", lat); end
        n_checks++;
        if (!bok) begin n_fail++; $display("FAIL counter_busy: busy low during window, required high"); end
        n_checks++;
        if (tog_a !== 32'h02040810) begin n_fail++; $display("FAIL counter_bits: got %h required 02040810", tog_a); end
        n_checks++;
        if (tot_a !== 12'd30) begin n_fail++; $display("FAIL counter_total: got %0d required 30", tot_a); end
        n_checks++;
        if (busy_a !== 1'b0) begin n_fail++; $display("FAIL counter_busy_done: got %b required 0", busy_a); end
        @(posedge clk); #1;
    endtask

    task automatic test_constant();
        int lat; bit bok;
        run_window(200, 1, lat, bok);
        n_checks++;
        if (lat !== 201) begin n_fail++; $display("FAIL const_latency: got %0d required 201", lat); end
        n_checks++;
        if (tog_a !== '0 || tot_a !== '0) begin
            n_fail++; $display("FAIL const_counts: got tog=%h tot=%0d required 0", tog_a, tot_a);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturate();
        int lat; bit bok;
        run_window(255, 2, lat, bok);
        n_checks++;
        if (lat !== 256) begin n_fail++; $display("FAIL sat_latency: got %0d required 256", lat); end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (int'(tog_a[k*8 +: 8]) !== 255 || int'(tog_b[k*4 +: 4]) !== 15) begin
                n_fail++;
                $display("FAIL sat_bit%0d: got %0d/%0d required 255/15", k, tog_a[k*8 +: 8], tog_b[k*4 +: 4]);
            end
        end
        n_checks++;
        if (tot_a !== 12'd1020 || tot_b !== 5'd31) begin
            n_fail++; $display("FAIL sat_total: got %0d/%0d required 1020/31", tot_a, tot_b);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat; bit bok; int n;
        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(1, 40);
            run_window(n, 3, lat, bok);
            n_checks++;
            if (lat !== n + 1 || !bok) begin
                n_fail++; $display("FAIL rand_timing run%0d: got lat=%0d busy_ok=%b required lat=%0d busy_ok=1", r, lat, bok, n + 1);
            end
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (int'(tog_a[k*8 +: 8]) !== exp_a[k] || int'(tog_b[k*4 +: 4]) !== exp_b[k]) begin
                    n_fail++;
                    $display("FAIL rand_bit%0d run%0d: got %0d/%0d required %0d/%0d", k, r,
                             tog_a[k*8 +: 8], tog_b[k*4 +: 4], exp_a[k], exp_b[k]);
                end
            end
            n_checks++;
            if (int'(tot_a) !== etot_a || int'(tot_b) !== etot_b) begin
                n_fail++; $display("FAIL rand_total run%0d: got %0d/%0d required %0d/%0d", r, tot_a, tot_b, etot_a, etot_b);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit bok; int n;
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 12);
            run_window(n, 3, lat, bok);
            n_checks++;
            if (lat !== n + 1 || int'(tot_a) !== etot_a) begin
                n_fail++; $display("FAIL b2b run%0d: got lat=%0d tot=%0d required lat=%0d tot=%0d", r, lat, tot_a, n + 1, etot_a);
            end
            @(posedge clk); #1;
            n_checks++;
            if (valid_a !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_drop run%0d: got %b required 0", r, valid_a); end
        end
    endtask

    task automatic test_backpressure();
        int lat; bit bok; bit stable;
        logic [31:0] snap_tog; logic [11:0] snap_tot;
        res_ready = 1'b0;
        run_window(12, 3, lat, bok);
        snap_tog = tog_a; snap_tot = tot_a;
        n_checks++;
        if (lat !== 13 || int'(tot_a) !== etot_a) begin
            n_fail++; $display("FAIL bp_result: got lat=%0d tot=%0d required lat=13 tot=%0d", lat, tot_a, etot_a);
        end
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            start = (i == 3); window_len = 8'd5;
            @(posedge clk); #1;
            start = 1'b0;
            if (valid_a !== 1'b1 || busy_a !== 1'b0 || tog_a !== snap_tog || tot_a !== snap_tot) stable = 1'b0;
        end
        n_checks++;
        if (!stable) begin n_fail++; $display("FAIL bp_stable: outputs changed during DONE, required held"); end
        res_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (valid_a !== 1'b0 || busy_a !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: got valid=%b busy=%b required 0/0", valid_a, busy_a);
        end
        @(posedge clk); #1;
        n_checks++;
        if (busy_a !== 1'b0 || tog_a !== snap_tog || tot_a !== snap_tot) begin
            n_fail++; $display("FAIL bp_idle_hold: got busy=%b tot=%0d required busy=0 tot=%0d", busy_a, tot_a, snap_tot);
        end
        run_window(8, 3, lat, bok);
        n_checks++;
        if (lat !== 9 || int'(tot_a) !== etot_a) begin
            n_fail++; $display("FAIL bp_restart: got lat=%0d tot=%0d required lat=9 tot=%0d", lat, tot_a, etot_a);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int lat; bit bok; bit seen;
        window_len = 8'd20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin probe = 4'($urandom); @(posedge clk); #1; end
        abort = 1'b1; probe = 4'($urandom);
        @(posedge clk); #1;
        abort = 1'b0;
        n_checks++;
        if (busy_a !== 1'b0 || tog_a !== '0 || tot_a !== '0) begin
            n_fail++; $display("FAIL abort_state: got busy=%b tog=%h tot=%0d required 0", busy_a, tog_a, tot_a);
        end
        seen = 1'b0;
        repeat (25) begin
            if (valid_a !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL abort_no_valid: got res_valid=1 required 0"); end
        run_window(10, 3, lat, bok);
        n_checks++;
        if (lat !== 11 || int'(tot_a) !== etot_a || int'(tog_a[7:0]) !== exp_a[0]) begin
            n_fail++; $display("FAIL abort_restart: got lat=%0d tot=%0d required lat=11 tot=%0d", lat, tot_a, etot_a);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        int lat; bit bok;
        window_len = 8'd30; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) begin probe = 4'($urandom); @(posedge clk); end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy_a, valid_a, tog_a, tot_a, busy_b, valid_b, tog_b, tot_b} !== '0) begin
            n_fail++; $display("FAIL async_reset: got busy=%b valid=%b tot=%0d required all zero", busy_a, valid_a, tot_a);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_window(0, 3, lat, bok);
        n_checks++;
        if (lat !== 1 || !bok || tog_a !== '0 || tot_a !== '0) begin
            n_fail++; $display("FAIL zero_window: got lat=%0d busy_ok=%b tot=%0d required lat=1 busy_ok=1 tot=0", lat, bok, tot_a);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_counter();
        test_constant();
        test_saturate();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/toggle_activity_monitor.md
# toggle_activity_monitor

Observes a free-running probe bus, such as the 4-bit counter output, and counts per-bit 0↔1 transitions over a programmable window of clock cycles. It is the consuming end of the switching-activity path: it turns a signal's toggling into on-chip toggle counts for the power-estimation accelerator, so activity no longer has to be extracted from a VCD dump. Results are presented on a valid/ready interface to the downstream power-model stage.

## Interface
- WIDTH, 4: probe bus width (≥1).
- CNT_W, 8: per-bit toggle counter width.
- TOT_W, 12: total toggle counter width.
- WIN_W, 8: window length register width.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a measurement, accepted only in IDLE.
- abort  in  1  cancels a measurement in ARM or COUNT.
- window_len  in  WIN_W  number of sampled cycles; latched when start is accepted.
- probe  in  WIDTH  monitored bus, synchronous to clk.
- busy  out  1  high in ARM and COUNT.
- res_valid  out  1  result available (DONE state).
- res_ready  in  1  downstream accepts the result.
- toggle_cnt  out  WIDTH*CNT_W  packed per-bit counts; bit k occupies [k*CNT_W +: CNT_W].
- total_cnt  out  TOT_W  sum of all per-bit toggles.

## Operation
- Reset values: all outputs are 0, state is IDLE, and the internal prev/cycle registers are 0.
- FSM states: IDLE, ARM, COUNT, DONE.
- IDLE, start=1:
  - Latch window_len into cyc_left.
  - Clear all counters.
  - Go to ARM. If window_len==0, go directly to DONE with all counts 0.
- ARM (one cycle): prev <= probe; go to COUNT.
- COUNT, each cycle:
  - t = probe ^ prev; prev <= probe.
  - For each bit with t[k]=1, toggle_cnt[k] += 1, saturating at 2^CNT_W−1.
  - total_cnt += popcount(t), saturating at 2^TOT_W−1. Saturation is checked on the full sum, with no wrap.
  - cyc_left -= 1. On the cycle where cyc_left==1, go to DONE after that sample.
- DONE: res_valid=1. toggle_cnt and total_cnt hold stable until res_valid && res_ready at a clock edge, then go to IDLE. Counts remain readable in IDLE until the next accepted start clears them.
- abort=1 in ARM or COUNT: go to IDLE next edge, clear counters, produce no res_valid. abort is ignored in IDLE and DONE.
- start is ignored outside IDLE, including in DONE during the handshake cycle. Returning to IDLE and starting again takes a separate start pulse.
- If abort and start are both high in IDLE, start wins (abort is ignored in IDLE).
- Asserting rst_n low at any time, including mid-COUNT or in DONE, forces the reset values immediately and drops any pending result.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Let start be sampled at edge E, with window_len=N≥1:
  - busy=1 from E+1 through the edge E+N+1.
  - ARM captures prev at edge E+1.
  - Samples are taken at edges E+2 … E+N+1.
  - res_valid=1 after edge E+N+1. Start-to-valid latency is N+1 edges.
- With N=0: res_valid=1 after edge E+1, and busy stays 0.
- Result is transferred on the edge where res_valid=1 and res_ready=1. res_valid=0 after that edge. If res_ready is held at 1, the earliest next start is accepted 1 cycle later.
- Throughput: one measurement per N+3 cycles with res_ready tied to 1.

## Test plan
- Free-running 4-bit counter (increment every cycle) on probe, N=16, res_ready=1:
  - Expect toggle_cnt = {2,4,8,16} (bit3..bit0) and total_cnt=30.
  - Expect res_valid exactly 17 edges after start.
- Constant probe=4'hA, N=200: expect all counts 0 and res_valid after 201 edges.
- probe toggling 4'h0↔4'hF every cycle, N=255, CNT_W=8:
  - Expect each bit count at 255 and total 1020.
  - Rerun with CNT_W=4, TOT_W=5: expect each bit to saturate at 15 and total to saturate at 31.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid.
  - Outputs stay stable, and a start pulse during DONE is ignored.
  - Raise res_ready: res_valid drops next edge, and a subsequent start is accepted.
- abort at the 5th COUNT cycle: busy drops next edge, res_valid never asserts, counts read 0, and a new start gives correct results.
- rst_n pulsed low mid-COUNT (asynchronously, between edges): all outputs are 0 immediately. window_len=0 start then yields res_valid after one edge with zero counts.
